// File: rtl/uart_rx_16x_if.sv
// Byte-delivery handshake between the UART receiver and its consumer.
// The receiver is the master: it owns data, valid and the error pulses; the consumer drives rx_ack.
interface uart_rx_16x_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ack;
   logic                 frame_err;
   logic                 overrun_err;

   modport master (
      output rx_data, rx_valid, frame_err, overrun_err,
      input  rx_ack
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, overrun_err,
      output rx_ack
   );
endinterface

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver on a 16x oversample tick derived from baud_clk (used as data, never as a clock).
// Majority-votes ticks 7/8/9 of each bit and delivers bytes over a valid/ack handshake.
module uart_rx_16x #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic          clk50MHz,
   input  logic          rst,
   input  logic          baud_clk,
   input  logic          rx,
   uart_rx_16x_if.master bus
);
   localparam int         IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [3:0] LAST  = 4'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t               state, state_nxt;
   logic [3:0]           s_cnt, s_cnt_nxt;
   logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic [1:0]           samp, samp_nxt;
   logic [DATA_BITS-1:0] data_nxt;
   logic                 valid_nxt, frame_nxt, overrun_nxt;
   logic                 rx_meta, rx_s, baud_d;
   logic                 tick, vote, valid_kept;

   // rx is asynchronous; sync flops reset to the idle-high line level.
   always_ff @(posedge clk50MHz or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         baud_d  <= 1'b0;
      end else begin
         // NOTE: non-blocking so rx_s takes last cycle's rx_meta, giving two real flop stages.
         rx_meta <= rx;
         rx_s    <= rx_meta;
         baud_d  <= baud_clk;
      end
   end

   assign tick       = baud_clk & ~baud_d;
   assign vote       = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
   assign valid_kept = bus.rx_valid & ~bus.rx_ack;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path infers a latch.
      state_nxt   = state;
      s_cnt_nxt   = s_cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      samp_nxt    = samp;
      data_nxt    = bus.rx_data;
      valid_nxt   = valid_kept;
      frame_nxt   = 1'b0;
      overrun_nxt = 1'b0;

      if (tick) begin
         if (state == ST_START || state == ST_DATA || state == ST_STOP) begin
            s_cnt_nxt = s_cnt + 4'd1;
            if (s_cnt == 4'd7) samp_nxt[0] = rx_s;
            if (s_cnt == 4'd8) samp_nxt[1] = rx_s;
         end

         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_nxt = ST_START;
                  s_cnt_nxt = 4'd1;
               end
            end
            ST_START: begin
               if (s_cnt == 4'd9 && vote) begin
                  state_nxt = ST_IDLE;
                  s_cnt_nxt = 4'd0;
               end else if (s_cnt == LAST) begin
                  state_nxt   = ST_DATA;
                  bit_idx_nxt = '0;
               end
            end
            ST_DATA: begin
               if (s_cnt == 4'd9) shreg_nxt = {vote, shreg[DATA_BITS-1:1]};
               if (s_cnt == LAST) begin
                  bit_idx_nxt = bit_idx + 1'b1;
                  if (bit_idx_nxt == IDX_W'(DATA_BITS)) state_nxt = ST_STOP;
               end
            end
            ST_STOP: begin
               // Leave at the stop-bit centre so the next start edge is not missed.
               if (s_cnt == 4'd9) begin
                  s_cnt_nxt = 4'd0;
                  if (!vote) begin
                     frame_nxt = 1'b1;
                     state_nxt = ST_BREAK;
                  end else begin
                     state_nxt = ST_IDLE;
                     if (valid_kept) begin
                        overrun_nxt = 1'b1;
                     end else begin
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
                     end
                  end
               end
            end
            ST_BREAK: begin
               if (rx_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk50MHz or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         s_cnt           <= 4'd0;
         bit_idx         <= '0;
         shreg           <= '0;
         samp            <= 2'b00;
         bus.rx_data     <= '0;
         bus.rx_valid    <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.overrun_err <= 1'b0;
      end else begin
         state           <= state_nxt;
         s_cnt           <= s_cnt_nxt;
         bit_idx         <= bit_idx_nxt;
         shreg           <= shreg_nxt;
         samp            <= samp_nxt;
         bus.rx_data     <= data_nxt;
         bus.rx_valid    <= valid_nxt;
         bus.frame_err   <= frame_nxt;
         bus.overrun_err <= overrun_nxt;
      end
   end
endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x: a table of single frames plus hand-written multi-frame sequences.
// baud_clk runs at 4 clocks per tick (64 clocks per bit) to keep frames short.
module tb_uart_rx_16x;
   localparam int DATA_BITS = 8;
   localparam int TICK_CLKS = 4;
   localparam int BIT_CLKS  = 16 * TICK_CLKS;
   // Edge of the stop-bit centre tick, counted from a start edge driven on a baud_clk rise:
   // the synchroniser hides the first tick, then 16*9+9 ticks reach the stop-bit vote.
   localparam int DELIVER_EDGE = 1 + TICK_CLKS * (1 + 16 * 9 + 9);

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_fe;
      int         exp_or;
   } vec_t;

   logic       clk50MHz = 1'b0;
   logic       rst      = 1'b1;
   logic       baud_clk = 1'b0;
   logic       rx       = 1'b1;
   logic [1:0] baud_div = 2'd0;
   int         n_cmp    = 0;
   int         n_bad    = 0;
   int         fe_cnt   = 0;
   int         or_cnt   = 0;
   int         fe0, or0;
   vec_t       vecs[8];

   uart_rx_16x_if #(.DATA_BITS(DATA_BITS)) bus ();

   uart_rx_16x #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(16)) dut (
      .clk50MHz(clk50MHz),
      .rst     (rst),
      .baud_clk(baud_clk),
      .rx      (rx),
      .bus     (bus.master)
   );

   always #10 clk50MHz = ~clk50MHz;

   always @(negedge clk50MHz) begin
      baud_div = baud_div + 2'd1;
      baud_clk = baud_div[1];
   end

   // Counting high cycles also catches pulses wider than one clock.
   always @(negedge clk50MHz) begin
      if (bus.frame_err === 1'b1)   fe_cnt++;
      if (bus.overrun_err === 1'b1) or_cnt++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, got no summary, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      repeat (BIT_CLKS) @(negedge clk50MHz);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk50MHz);
   endtask

   task automatic align();
      @(posedge baud_clk);
   endtask

   task automatic ack_pulse();
      bus.rx_ack = 1'b1;
      @(negedge clk50MHz);
      bus.rx_ack = 1'b0;
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0, 0};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1, 0};
      vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 0, 0};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 0, 0};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0, 0};
      vecs[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0, 0};
      vecs[6] = '{8'h01, 1'b1, 1'b1, 8'h01, 0, 0};
      vecs[7] = '{8'h80, 1'b1, 1'b1, 8'h80, 0, 0};

      bus.rx_ack = 1'b0;
      repeat (3) @(negedge clk50MHz);
      check("reset rx_data", bus.rx_data, 8'h00);
      check("reset rx_valid", bus.rx_valid, 1'b0);
      check("reset frame_err", bus.frame_err, 1'b0);
      check("reset overrun_err", bus.overrun_err, 1'b0);
      rst = 1'b0;
      idle_bits(2);

      // Good frame held until acknowledged.
      fe0 = fe_cnt; or0 = or_cnt;
      align();
      send_frame(8'hA5, 1'b1);
      idle_bits(1);
      check("A5 valid", bus.rx_valid, 1'b1);
      check("A5 data", bus.rx_data, 8'hA5);
      idle_bits(3);
      check("A5 valid held", bus.rx_valid, 1'b1);
      check("A5 frame_err pulses", fe_cnt - fe0, 0);
      check("A5 overrun pulses", or_cnt - or0, 0);
      ack_pulse();
      check("A5 valid after ack", bus.rx_valid, 1'b0);
      check("A5 data after ack", bus.rx_data, 8'hA5);

      // Three-tick low glitch is a false start.
      fe0 = fe_cnt; or0 = or_cnt;
      align();
      rx = 1'b0;
      repeat (3 * TICK_CLKS) @(negedge clk50MHz);
      idle_bits(3);
      check("glitch valid", bus.rx_valid, 1'b0);
      check("glitch frame_err pulses", fe_cnt - fe0, 0);
      check("glitch overrun pulses", or_cnt - or0, 0);

      // Bad stop bit then line held low: one frame error, then recovery.
      fe0 = fe_cnt; or0 = or_cnt;
      align();
      send_frame(8'h3C, 1'b0);
      repeat (40 * TICK_CLKS) @(negedge clk50MHz);
      idle_bits(2);
      check("break frame_err pulses", fe_cnt - fe0, 1);
      check("break valid", bus.rx_valid, 1'b0);
      check("break data unchanged", bus.rx_data, 8'hA5);
      align();
      send_frame(8'h81, 1'b1);
      idle_bits(2);
      check("after break data", bus.rx_data, 8'h81);
      check("after break valid", bus.rx_valid, 1'b1);
      check("after break frame_err pulses", fe_cnt - fe0, 1);
      ack_pulse();

      // Back-to-back without ack: second byte overruns.
      fe0 = fe_cnt; or0 = or_cnt;
      align();
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle_bits(2);
      check("overrun data kept", bus.rx_data, 8'h11);
      check("overrun valid", bus.rx_valid, 1'b1);
      check("overrun pulses", or_cnt - or0, 1);
      check("overrun frame_err pulses", fe_cnt - fe0, 0);
      ack_pulse();

      // Ack on the exact delivery cycle of the second byte: accepted, no overrun.
      fe0 = fe_cnt; or0 = or_cnt;
      align();
      send_frame(8'h00, 1'b1);
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (DELIVER_EDGE - 1) @(negedge clk50MHz);
            check("pre-delivery data", bus.rx_data, 8'h00);
            check("pre-delivery valid", bus.rx_valid, 1'b1);
            bus.rx_ack = 1'b1;
            @(negedge clk50MHz);
            bus.rx_ack = 1'b0;
            check("same-cycle ack data", bus.rx_data, 8'hFF);
            check("same-cycle ack valid", bus.rx_valid, 1'b1);
         end
      join
      idle_bits(2);
      check("same-cycle ack overrun pulses", or_cnt - or0, 0);
      check("same-cycle ack valid held", bus.rx_valid, 1'b1);

      // Reset during data bit 4 clears outputs asynchronously.
      align();
      fork
         send_frame(8'h5A, 1'b1);
         begin
            repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk50MHz);
            rst = 1'b1;
            #2;
            check("async reset data", bus.rx_data, 8'h00);
            check("async reset valid", bus.rx_valid, 1'b0);
            check("async reset frame_err", bus.frame_err, 1'b0);
            check("async reset overrun_err", bus.overrun_err, 1'b0);
            repeat (3) @(negedge clk50MHz);
            rst = 1'b0;
         end
      join
      idle_bits(12);
      ack_pulse();
      align();
      send_frame(8'hC3, 1'b1);
      idle_bits(2);
      check("post-reset data", bus.rx_data, 8'hC3);
      check("post-reset valid", bus.rx_valid, 1'b1);

      // Table of isolated frames, each preceded by an ack to clear rx_valid.
      for (int i = 0; i < 8; i++) begin
         ack_pulse();
         fe0 = fe_cnt; or0 = or_cnt;
         idle_bits(1);
         align();
         send_frame(vecs[i].data, vecs[i].stop);
         idle_bits(2);
         check($sformatf("vec%0d valid", i), bus.rx_valid, vecs[i].exp_valid);
         check($sformatf("vec%0d data", i), bus.rx_data, vecs[i].exp_data);
         check($sformatf("vec%0d frame_err pulses", i), fe_cnt - fe0, vecs[i].exp_fe);
         check($sformatf("vec%0d overrun pulses", i), or_cnt - or0, vecs[i].exp_or);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
